// File: rtl/instr_encoder_if.sv
// Request/response bundle for instr_encoder: field-level request in, packed RV32I word out.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_kind;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        out_err;

    modport master (
        output in_valid, in_kind, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_word, out_err
    );

    modport slave (
        input  in_valid, in_kind, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_word, out_err
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs {addi, add, beq, jal} field descriptions into RV32I words behind a 2-entry elastic buffer.
// Optional macro ENC_ERRCNT_EN adds a saturating illegal-request counter on err_count.
module instr_encoder #(
    parameter int DEPTH    = 2,
    parameter int ERRCNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    instr_encoder_if.slave      bus
`ifdef ENC_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0] err_count
`endif
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] word;
        logic        err;
    } entry_t;

    entry_t      enc;
    entry_t      mem [2];
    logic        rd_ptr, wr_ptr;
    logic [1:0]  count;
    logic        push, pop;
    logic [31:0] raw;
    logic [31:0] imm;
    logic        legal;

    assign imm = bus.in_imm;

    // Encode and legality check happen on the request side only; the buffer stores finished words.
    always_comb begin
        raw   = NOP;
        legal = 1'b0;
        case (bus.in_kind)
            4'b1000: begin
                raw   = {imm[11:0], bus.in_rs1, 3'b000, bus.in_rd, 7'b0010011};
                legal = ($signed(imm) >= -32'sd2048) && ($signed(imm) <= 32'sd2047);
            end
            4'b0100: begin
                raw   = {7'b0000000, bus.in_rs2, bus.in_rs1, 3'b000, bus.in_rd, 7'b0110011};
                legal = 1'b1;
            end
            4'b0010: begin
                raw   = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, 3'b000,
                         imm[4:1], imm[11], 7'b1100011};
                legal = !imm[0] && ($signed(imm) >= -32'sd4096) && ($signed(imm) <= 32'sd4094);
            end
            4'b0001: begin
                raw   = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, 7'b1101111};
                legal = !imm[0] && ($signed(imm) >= -32'sd1048576) &&
                        ($signed(imm) <= 32'sd1048574);
            end
            default: begin
                raw   = NOP;
                legal = 1'b0;
            end
        endcase
        enc.word = legal ? raw : NOP;
        enc.err  = !legal;
    end

    // Ready comes from the registered count only, so no out_ready -> in_ready path exists.
    assign bus.in_ready  = (count < 2'(DEPTH));
    assign bus.out_valid = (count != 2'd0);
    assign bus.out_word  = mem[rd_ptr].word;
    assign bus.out_err   = mem[rd_ptr].err;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) mem[i] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= enc;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef ENC_ERRCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_count <= '0;
        else if (push && enc.err && (err_count != '1))
            err_count <= err_count + 1'b1;
    end
`endif

endmodule
